// File: rtl/tcm_mem_ram_dp_pkg.sv
// rtl/tcm_mem_ram_dp_pkg.sv - shared types and byte helpers for the dual-port TCM
//
// Purpose: read-mode constants, the sequencer state type and the byte-lane
// helpers used by tcm_mem_ram_dp. Helpers work on the widest legal word
// (128 bits / 16 lanes); callers size-cast in and out.
package mem_defines;

    localparam int MAX_DW = 128;
    localparam int MAX_NB = MAX_DW / 8;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } tcm_state_t;

    // Replace the lanes selected by be with the matching lanes of new_word.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_NB-1:0] be
    );
        logic [MAX_DW-1:0] res;
        res = old_word;
        for (int b = 0; b < MAX_NB; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // One even-parity bit per byte lane (XOR of the lane's bits).
    function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DW-1:0] word);
        logic [MAX_NB-1:0] p;
        for (int b = 0; b < MAX_NB; b++) begin
            p[b] = ^word[b*8 +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/tcm_mem_ram_dp_rd_pipe.sv
// rtl/tcm_mem_ram_dp_rd_pipe.sv - per-port valid/data/err delay line
//
// Purpose: delays a response by LAT register stages. Data stages only load
// when their valid input is set, so data_o holds between pulses.
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   valid_i/data_i/err_i response captured at the accepting edge
//   valid_o/data_o/err_o response LAT cycles later (err only with valid)
module tcm_rd_pipe #(
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          err_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          err_o
);

    logic [LAT-1:0]         vld_q, vld_d;
    logic [LAT-1:0]         err_q, err_d;
    logic [LAT-1:0][DW-1:0] dat_q, dat_d;

    // Index 0 of each chain is the stage input, index i+1 is stage i's output.
    logic [LAT:0]           vld_chain, err_chain;
    logic [LAT:0][DW-1:0]   dat_chain;

    always_comb begin
        vld_chain = {vld_q, valid_i};
        err_chain = {err_q, err_i};
        dat_chain = {dat_q, data_i};
        for (int i = 0; i < LAT; i++) begin
            vld_d[i] = vld_chain[i];
            err_d[i] = vld_chain[i] & err_chain[i];
            dat_d[i] = vld_chain[i] ? dat_chain[i] : dat_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            err_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            dat_q <= dat_d;
        end
    end

    assign valid_o = vld_q[LAT-1];
    assign err_o   = err_q[LAT-1];
    assign data_o  = dat_q[LAT-1];

endmodule

// File: rtl/tcm_mem_ram_dp.sv
// rtl/tcm_mem_ram_dp.sv - parametrised dual-port tightly-coupled memory
//
// Purpose: two-port word memory (port 0 fetch, port 1 load/store) with byte
// enables, request/valid handshake, selectable read latency and same-port
// read mode, same-address write arbitration and a zeroing sweep after reset.
// Optional macro TCM_MEM_RAM_PARITY_EN adds one even-parity bit per byte.
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   ready_o                   requests accepted (sequencer in RUN)
//   reqN_i, wrN_i             request strobe, byte enables (all-zero = read)
//   addrN_i, dataN_i          word address, write data
//   dataN_o, validN_o, errN_o response data, valid pulse, parity error
//   collision_o               overlapping same-address writes, pulse
module tcm_mem_ram_dp
    import mem_defines::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int READ_MODE    = 0,
    parameter int INIT_ZERO    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    output logic                    ready_o,
    input  logic                    req0_i,
    input  logic                    req1_i,
    input  logic [DATA_WIDTH/8-1:0] wr0_i,
    input  logic [DATA_WIDTH/8-1:0] wr1_i,
    input  logic [ADDR_WIDTH-1:0]   addr0_i,
    input  logic [ADDR_WIDTH-1:0]   addr1_i,
    input  logic [DATA_WIDTH-1:0]   data0_i,
    input  logic [DATA_WIDTH-1:0]   data1_i,
    output logic [DATA_WIDTH-1:0]   data0_o,
    output logic [DATA_WIDTH-1:0]   data1_o,
    output logic                    valid0_o,
    output logic                    valid1_o,
    output logic                    collision_o,
    output logic                    err0_o,
    output logic                    err1_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    tcm_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   collision_q, collision_d;

    logic [DATA_WIDTH-1:0]  mem_array [DEPTH];
`ifdef TCM_MEM_RAM_PARITY_EN
    logic [NB-1:0]          par_array [DEPTH];
    logic [NB-1:0]          wpar [2];
`endif

    // Both ports folded into two-entry arrays so read and write paths share code.
    logic [1:0]             acc;
    logic [NB-1:0]          be    [2];
    logic [ADDR_WIDTH-1:0]  addr  [2];
    logic [DATA_WIDTH-1:0]  din   [2];
    logic [DATA_WIDTH-1:0]  rdata [2];
    logic [1:0]             rerr;
    logic                   ready;

    assign ready   = (state_q == RUN);
    assign ready_o = ready;
    assign acc     = {req1_i & ready, req0_i & ready};
    assign be[0]   = wr0_i;
    assign be[1]   = wr1_i;
    assign addr[0] = addr0_i;
    assign addr[1] = addr1_i;
    assign din[0]  = data0_i;
    assign din[1]  = data1_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = (INIT_ZERO != 0) ? INIT : RUN;
            end
            INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (&cnt_q) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Reads always see the pre-edge array, so cross-port reads are read-first;
    // only a port's own write is merged in write-first mode.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (READ_MODE == WRITE_FIRST && (|be[p])) begin
                rdata[p] = DATA_WIDTH'(byte_merge(MAX_DW'(mem_array[addr[p]]),
                                                  MAX_DW'(din[p]), MAX_NB'(be[p])));
            end else begin
                rdata[p] = mem_array[addr[p]];
            end
`ifdef TCM_MEM_RAM_PARITY_EN
            rerr[p] = |(NB'(byte_parity(MAX_DW'(mem_array[addr[p]]))) ^ par_array[addr[p]]);
            wpar[p] = NB'(byte_parity(MAX_DW'(din[p])));
`else
            rerr[p] = 1'b0;
`endif
        end
    end

    assign collision_d = acc[0] & acc[1] & (addr0_i == addr1_i) & (|(wr0_i & wr1_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
        end
    end

    // Port 1 is applied first so that port 0 overrides it on shared byte lanes.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            mem_array[cnt_q] <= '0;
`ifdef TCM_MEM_RAM_PARITY_EN
            par_array[cnt_q] <= '0;
`endif
        end else begin
            for (int p = 1; p >= 0; p--) begin
                if (acc[p]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[p][b]) begin
                            mem_array[addr[p]][b*8 +: 8] <= din[p][b*8 +: 8];
`ifdef TCM_MEM_RAM_PARITY_EN
                            par_array[addr[p]][b] <= wpar[p][b];
`endif
                        end
                    end
                end
            end
        end
    end

    assign collision_o = collision_q;

    tcm_rd_pipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_pipe0 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (acc[0]),
        .data_i  (rdata[0]),
        .err_i   (rerr[0]),
        .valid_o (valid0_o),
        .data_o  (data0_o),
        .err_o   (err0_o)
    );

    tcm_rd_pipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_pipe1 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (acc[1]),
        .data_i  (rdata[1]),
        .err_i   (rerr[1]),
        .valid_o (valid1_o),
        .data_o  (data1_o),
        .err_o   (err1_o)
    );

endmodule

// File: tb/tb_tcm_mem_ram_dp.sv
// tb/tb_tcm_mem_ram_dp.sv - randomized self-checking bench for tcm_mem_ram_dp
module tb_tcm_mem_ram_dp;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;
    localparam int MODE  = 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          ready_o;
    logic          req0_i, req1_i;
    logic [3:0]    wr0_i, wr1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] data0_i, data1_i;
    logic [DW-1:0] data0_o, data1_o;
    logic          valid0_o, valid1_o, collision_o, err0_o, err1_o;

    always #5 clk_i = ~clk_i;

    tcm_mem_ram_dp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT),
        .READ_MODE(MODE), .INIT_ZERO(1)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ready_o(ready_o),
        .req0_i(req0_i), .req1_i(req1_i), .wr0_i(wr0_i), .wr1_i(wr1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .data0_i(data0_i), .data1_i(data1_i),
        .data0_o(data0_o), .data1_o(data1_o), .valid0_o(valid0_o), .valid1_o(valid1_o),
        .collision_o(collision_o), .err0_o(err0_o), .err1_o(err1_o)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem  [DEPTH];
    logic [3:0]  bad_byte [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          ecount = 0;
    int          since = 0;
    int          rdy_at = -1;
    int          v1_at = 0;
    int          col_cnt = 0;
    logic [31:0] hold0 = '0, hold1 = '0, obs0 = '0, obs1 = '0;
    logic        err_obs0 = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic drive_idle_inputs();
        req0_i = 0; req1_i = 0; wr0_i = 0; wr1_i = 0;
        addr0_i = 0; addr1_i = 0; data0_i = 0; data1_i = 0;
    endtask

    task automatic cycle(input logic r0, input logic [3:0] w0, input logic [3:0] a0, input logic [31:0] d0,
                         input logic r1, input logic [3:0] w1, input logic [3:0] a1, input logic [31:0] d1);
        logic        rdy, ecol, ev, ee;
        logic [31:0] o0, o1, m0, m1;
        exp_t        e;
        @(negedge clk_i);
        req0_i = r0; wr0_i = w0; addr0_i = a0; data0_i = d0;
        req1_i = r1; wr1_i = w1; addr1_i = a1; data1_i = d1;
        @(posedge clk_i);
        ecount++;
        rdy = (since >= DEPTH + 1);
        since++;
        ecol = 1'b0;
        if (rdy) begin
            o0 = ref_mem[a0];
            o1 = ref_mem[a1];
            m0 = lane_mask(w0);
            m1 = lane_mask(w1);
            if (r0) q0.push_back('{due: ecount + LAT - 1, err: |bad_byte[a0],
                                   data: (MODE == 1) ? ((o0 & ~m0) | (d0 & m0)) : o0});
            if (r1) q1.push_back('{due: ecount + LAT - 1, err: |bad_byte[a1],
                                   data: (MODE == 1) ? ((o1 & ~m1) | (d1 & m1)) : o1});
            if (r1) begin
                ref_mem[a1]  = (ref_mem[a1] & ~m1) | (d1 & m1);
                bad_byte[a1] = bad_byte[a1] & ~w1;
            end
            if (r0) begin
                ref_mem[a0]  = (ref_mem[a0] & ~m0) | (d0 & m0);
                bad_byte[a0] = bad_byte[a0] & ~w0;
            end
            ecol = r0 && r1 && (a0 == a1) && ((w0 & w1) != 0);
        end
        if (since == DEPTH + 1) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i]  = '0;
                bad_byte[i] = '0;
            end
        end
        #1;
        check_eq("ready", ready_o, since >= DEPTH + 1);
        check_eq("collision", collision_o, ecol);
        ev = 0; ee = 0;
        if (q0.size() > 0 && q0[0].due == ecount) begin
            e = q0.pop_front(); ev = 1; ee = e.err; hold0 = e.data;
        end
        check_eq("valid0", valid0_o, ev);
        check_eq("data0", data0_o, hold0);
        check_eq("err0", err0_o, ee);
        ev = 0; ee = 0;
        if (q1.size() > 0 && q1[0].due == ecount) begin
            e = q1.pop_front(); ev = 1; ee = e.err; hold1 = e.data;
        end
        check_eq("valid1", valid1_o, ev);
        check_eq("data1", data1_o, hold1);
        check_eq("err1", err1_o, ee);
        if (valid0_o) begin obs0 = data0_o; err_obs0 = err0_o; end
        if (valid1_o) begin obs1 = data1_o; v1_at = ecount; end
        if (collision_o) col_cnt++;
        if (ready_o && rdy_at < 0) rdy_at = since;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycle();
        logic [31:0] r, s, t;
        r = $urandom; s = $urandom; t = $urandom;
        cycle(r[0], r[1] ? r[7:4] : 4'h0, r[11:8], s,
              r[2], r[3] ? r[15:12] : 4'h0, r[16] ? r[11:8] : r[19:16], t);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        drive_idle_inputs();
        #1;
        check_eq("rst_ready", ready_o, 0);
        check_eq("rst_valid0", valid0_o, 0);
        check_eq("rst_valid1", valid1_o, 0);
        check_eq("rst_data0", data0_o, 0);
        check_eq("rst_data1", data1_o, 0);
        check_eq("rst_collision", collision_o, 0);
        q0.delete(); q1.delete();
        hold0 = '0; hold1 = '0;
        since = 0; rdy_at = -1;
        repeat (2) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e_req;
        drive_idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            dut.mem_array[i] = 32'hDEADBEEF;
            ref_mem[i]  = 32'hDEADBEEF;
            bad_byte[i] = '0;
        end
        do_reset();

        // Abort the sweep with the counter at 8, then let a full sweep run.
        repeat (9) rand_cycle();
        do_reset();
        for (int i = 0; i < 100 && rdy_at < 0; i++) rand_cycle();
        check_eq("ready_delay", rdy_at, DEPTH + 1);

        for (int a = 0; a < DEPTH; a++) begin
            cycle(1, 0, 4'(a), $urandom, 1, 0, 4'(DEPTH - 1 - a), $urandom);
        end
        idle(LAT + 1);
        check_eq("init_zero0", obs0, 32'h0);
        check_eq("init_zero1", obs1, 32'h0);

        cycle(1, 4'hF, 5, 32'h11223344, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 5, 0);
        e_req = ecount;
        idle(LAT + 1);
        check_eq("lat_edges", v1_at - e_req, LAT - 1);
        check_eq("lat_data", obs1, 32'h11223344);

        cycle(1, 4'b0101, 5, 32'hAABBCCDD, 0, 0, 0, 0);
        idle(LAT + 1);
        check_eq("be_ret", obs0, (MODE == 1) ? 32'h11BB33DD : 32'h11223344);
        cycle(0, 0, 0, 0, 1, 0, 5, 0);
        idle(LAT + 1);
        check_eq("be_stored", obs1, 32'h11BB33DD);

        col_cnt = 0;
        cycle(1, 4'b0011, 7, 32'h000000AA, 1, 4'b0110, 7, 32'h0000BB00);
        idle(LAT + 1);
        check_eq("col_pulses", col_cnt, 1);
        cycle(1, 0, 7, 0, 0, 0, 0, 0);
        idle(LAT + 1);
        check_eq("col_word", obs0, 32'h000000AA);

        cycle(1, 4'hF, 3, 32'h55, 1, 0, 3, 0);
        idle(LAT + 1);
        check_eq("xport_old", obs1, 32'h0);
        cycle(0, 0, 0, 0, 1, 0, 3, 0);
        idle(LAT + 1);
        check_eq("xport_new", obs1, 32'h55);

`ifdef TCM_MEM_RAM_PARITY_EN
        dut.mem_array[2] = dut.mem_array[2] ^ 32'h0000_0100;
        ref_mem[2]  = ref_mem[2] ^ 32'h0000_0100;
        bad_byte[2] = 4'b0010;
        cycle(1, 0, 2, 0, 0, 0, 0, 0);
        idle(LAT + 1);
        check_eq("parity_err", err_obs0, 1);
`endif

        repeat (1500) rand_cycle();
        idle(LAT + 1);

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcm_mem_ram_dp.md
Name: tcm_mem_ram_dp

Overview:
- Parametrised dual-port tightly-coupled memory for the core's instruction and data paths.
- Successor to the fixed 32-bit dual-port TCM, adding:
  - configurable data width and depth,
  - selectable read latency (1 or 2),
  - selectable same-port read mode,
  - request/valid handshake,
  - deterministic same-address collision resolution,
  - hardware zero-initialisation sequencer.
- One clock domain. Port 0 serves instruction fetch; port 1 serves load/store.

Parameters:
- ADDR_WIDTH, 14: word-address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; multiple of 8, range 8..128.
- READ_LATENCY, 1: cycles from accepted request to valid_o; legal values 1 or 2.
- READ_MODE, 0: same-port write returns 0 = old word (read-first), 1 = merged new word (write-first).
- INIT_ZERO, 1: 1 = run the zeroing sweep after reset; 0 = skip it.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- ready_o  out  1  memory accepts requests.
- req0_i / req1_i  in  1  request strobe, per port.
- wr0_i / wr1_i  in  DATA_WIDTH/8  byte write enables; all-zero = read.
- addr0_i / addr1_i  in  ADDR_WIDTH  word address.
- data0_i / data1_i  in  DATA_WIDTH  write data.
- data0_o / data1_o  out  DATA_WIDTH  read data.
- valid0_o / valid1_o  out  1  data_o valid, one-cycle pulse.
- collision_o  out  1  same-address write conflict occurred, pulse.
- err0_o / err1_o  out  1  parity error, aligned with valid.

Behaviour:
- Reset values (async, on rst_n_i low): ready_o=0, valid*=0, data*_o=0, collision_o=0, err*=0, state=IDLE, init counter=0. Array contents are not reset.
- FSM states IDLE, INIT, RUN:
  - IDLE: first clock after reset release goes to INIT if INIT_ZERO=1, else RUN.
  - INIT: writes zero to the word at the counter each cycle, counter +1. After word 2**ADDR_WIDTH-1 is written, go to RUN. ready_o stays 0 throughout; sweep takes exactly 2**ADDR_WIDTH cycles.
  - RUN: ready_o=1. No exit except reset.
  - Reset asserted mid-INIT aborts the sweep; the next release restarts it from word 0.
- Request accept rule: a request is accepted when req_i=1 and ready_o=1 at the rising edge. Requests while ready_o=0 are dropped silently; no valid is produced.
- Every accepted request, read or write, produces exactly one valid pulse READ_LATENCY cycles later, in order. Back-to-back requests give throughput of 1 per cycle per port.
- READ_LATENCY=2 adds an output register stage. data_o holds its last value between valid pulses.
- Writes: enabled bytes update at the accepting edge.
- Same-port write, returned data:
  - READ_MODE=0: pre-write word.
  - READ_MODE=1: pre-write word with the enabled bytes replaced by data_i.
- Cross-port same cycle, same address: a read on one port while the other writes returns the pre-write word, regardless of READ_MODE.
- Both ports writing the same address:
  - port 0 wins each byte enabled on both ports;
  - non-overlapping bytes from both ports are written;
  - collision_o pulses 1 cycle after the edge only when the enabled byte sets overlap.
- Address decode covers the full range; no out-of-range case exists.

Optional Feature:
- Macro: TCM_MEM_RAM_PARITY_EN.
- Defined:
  - each stored byte carries an even-parity bit;
  - parity is generated on write, including INIT zeros;
  - parity is checked on read;
  - err*_o=1 with the valid pulse if any byte of the returned word mismatches;
  - data is returned unmodified.
- Undefined: no parity storage; err0_o and err1_o are tied 0.

Decomposition:
- mem_defines package holds:
  - READ_FIRST/WRITE_FIRST constants;
  - tcm_state_t enum (IDLE, INIT, RUN);
  - function byte_merge(old, new, be);
  - function byte_parity(word).
- Sub-module tcm_rd_pipe: per-port valid/data/err delay line of depth READ_LATENCY, instantiated twice.

Test Plan:
- Init sweep: ADDR_WIDTH=4, INIT_ZERO=1, memory pre-filled 0xDEADBEEF, release reset.
  - ready_o rises exactly 16 cycles after IDLE exit.
  - Reading addr 0..15 returns 0x00000000.
  - Requests issued during INIT yield no valid pulse.
- Latency: READ_LATENCY=2, write 0x11223344 to addr 5, then read on port 1.
  - valid1_o appears 2 cycles after each request.
  - The read returns 0x11223344.
- Byte enables and read mode: addr 5 holds 0x11223344; port 0 writes wr=4'b0101 with data 0xAABBCCDD.
  - READ_MODE=0: returns 0x11223344.
  - READ_MODE=1: returns 0x11BB33DD.
  - Subsequent read returns 0x11BB33DD.
- Collision: addr 7; port 0 writes wr=4'b0011 data 0x000000AA; port 1 writes wr=4'b0110 data 0x0000BB00 in the same cycle.
  - Stored word: 0x000000AA merged with byte 2 from port 1's data (=0x00), i.e. bytes 0–1 from port 0, byte 2 from port 1.
  - collision_o pulses once.
- Cross-port read: port 0 writes 0x55 to addr 3 while port 1 reads addr 3 in the same cycle.
  - Port 1 returns the old value.
  - The next port-1 read returns 0x55.
- Reset mid-INIT, then parity:
  - Pulse rst_n_i low at counter=8: ready_o=0, valid*=0; after release the sweep restarts at 0 and takes the full 2**ADDR_WIDTH cycles.
  - With TCM_MEM_RAM_PARITY_EN defined: flip a stored bit via backdoor; the read gives err0_o=1 with valid0_o.
